// File: rtl/wb_arbiter.sv
// wb_arbiter: buffers the four execute-stage result channels and drains them
// through a single scoreboard write port with round-robin arbitration.
// Ports: clk_i/rst_ni (async active-low), flush_i; per-channel wb_valid_i,
//   wb_result_i, wb_trans_id_i, wb_exception_i (no ready); sb_valid_o/sb_ready_i
//   with sb_result_o, sb_trans_id_o, sb_exception_o; stall_issue_o, overflow_o,
//   conflict_cnt_o.
// Optional feature macro: WB_ARB_STATS_EN builds the request-conflict counter.

package wb_arbiter_pkg;
  localparam int unsigned TRANS_ID_BITS = 4;

  typedef struct packed {
    logic        valid;
    logic [4:0]  cause;
    logic [31:0] tval;
  } exception_t;
endpackage

// Per-channel result FIFO with pointer/count bookkeeping.
// Latency: 1 cycle from push to head; head is read combinationally.
// No backpressure: a push into a full FIFO is dropped unless a pop frees the slot.
module wb_arbiter_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       data_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       data_o,
  output logic [$clog2(Depth):0] cnt_d_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_q, wr_q;
  logic [PtrW:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle;
  // the write lands in the slot being vacated.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q];

  always_comb begin
    cnt_d_o = cnt_q;
    if (flush_i) begin
      cnt_d_o = '0;
    end else if (do_push && !do_pop) begin
      cnt_d_o = cnt_q + (PtrW+1)'(1);
    end else if (do_pop && !do_push) begin
      cnt_d_o = cnt_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d_o;
      if (flush_i) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (do_push) wr_q <= wr_q + PtrW'(1);
        if (do_pop)  rd_q <= rd_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end
endmodule

// Writeback arbiter: per-channel FIFOs drained round-robin into the scoreboard.
// Latency: 0 cycles for a winning live input with an empty FIFO, else queued.
// Backpressure: sb_ready_i stalls draining; stall_issue_o warns before overflow.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NrWbPorts = 4,
  parameter int unsigned Depth     = 4,
  parameter int unsigned AfThresh  = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    flush_i,
  input  logic [NrWbPorts-1:0]                    wb_valid_i,
  input  logic [NrWbPorts-1:0][63:0]              wb_result_i,
  input  logic [NrWbPorts-1:0][TRANS_ID_BITS-1:0] wb_trans_id_i,
  input  exception_t [NrWbPorts-1:0]              wb_exception_i,
  output logic                                    sb_valid_o,
  input  logic                                    sb_ready_i,
  output logic [63:0]                             sb_result_o,
  output logic [TRANS_ID_BITS-1:0]                sb_trans_id_o,
  output exception_t                              sb_exception_o,
  output logic                                    stall_issue_o,
  output logic                                    overflow_o,
  output logic [31:0]                             conflict_cnt_o
);
  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam int unsigned IdxW = $clog2(NrWbPorts);

  typedef struct packed {
    logic [63:0]              result;
    logic [TRANS_ID_BITS-1:0] trans_id;
    exception_t               exception;
  } entry_t;

  entry_t                          live [NrWbPorts];
  entry_t                          head [NrWbPorts];
  entry_t                          cand [NrWbPorts];
  entry_t                          sb_sel;
  logic [NrWbPorts-1:0]            req, empty, full, push, pop, gnt;
  logic [NrWbPorts-1:0][CntW-1:0]  cnt_d;
  logic [NrWbPorts-1:0]            rr_q, rr_d;
  logic [IdxW-1:0]                 rr_idx, gnt_idx;
  logic [IdxW:0]                   pos;
  logic                            found, xfer, stall_d, ovf_set;

  for (genvar i = 0; i < NrWbPorts; i++) begin : g_chan
    assign live[i] = '{result: wb_result_i[i], trans_id: wb_trans_id_i[i],
                       exception: wb_exception_i[i]};
    assign req[i]  = !empty[i] || wb_valid_i[i];
    // Empty FIFO: present the live input directly (fall-through).
    assign cand[i] = empty[i] ? live[i] : head[i];
    // A live input consumed by fall-through never enters the FIFO.
    assign push[i] = wb_valid_i[i] && !flush_i && !(empty[i] && gnt[i] && xfer);
    assign pop[i]  = gnt[i] && !empty[i] && xfer;

    wb_arbiter_fifo #(.Width($bits(entry_t)), .Depth(Depth)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (push[i]),
      .data_i  (live[i]),
      .pop_i   (pop[i]),
      .data_o  (head[i]),
      .cnt_d_o (cnt_d[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  // Grant the first requester at or after the one-hot priority pointer.
  always_comb begin
    rr_idx  = '0;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int i = 0; i < NrWbPorts; i++) begin
      if (rr_q[i]) rr_idx = IdxW'(i);
    end
    for (int k = 0; k < NrWbPorts; k++) begin
      pos = {1'b0, rr_idx} + (IdxW+1)'(k);
      if (pos >= (IdxW+1)'(NrWbPorts)) pos = pos - (IdxW+1)'(NrWbPorts);
      if (!found && req[pos[IdxW-1:0]]) begin
        found              = 1'b1;
        gnt_idx            = pos[IdxW-1:0];
        gnt[pos[IdxW-1:0]] = 1'b1;
      end
    end
  end

  assign sb_valid_o     = (|req) && !flush_i;
  assign xfer           = sb_valid_o && sb_ready_i;
  assign sb_sel         = sb_valid_o ? cand[gnt_idx] : '0;
  assign sb_result_o    = sb_sel.result;
  assign sb_trans_id_o  = sb_sel.trans_id;
  assign sb_exception_o = sb_sel.exception;

  assign ovf_set = |(push & full & ~pop);

  always_comb begin
    rr_d = rr_q;
    if (flush_i) begin
      rr_d = NrWbPorts'(1);
    end else if (xfer) begin
      rr_d = {gnt[NrWbPorts-2:0], gnt[NrWbPorts-1]};
    end
  end

  always_comb begin
    stall_d = 1'b0;
    for (int i = 0; i < NrWbPorts; i++) begin
      if ((32'(Depth) - 32'(cnt_d[i])) <= 32'(AfThresh)) stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q          <= NrWbPorts'(1);
      stall_issue_o <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      rr_q          <= rr_d;
      stall_issue_o <= stall_d;
      if (ovf_set) overflow_o <= 1'b1;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [31:0] conflict_q;
  logic        multi_req;

  assign multi_req = ($countones(req) > 1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_q <= '0;
    end else if (multi_req && !flush_i && (conflict_q != '1)) begin
      conflict_q <= conflict_q + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_q;
`else
  assign conflict_cnt_o = '0;
`endif
endmodule
